// File: rtl/ctrl_pkg.sv
// Shared encodings for the counter controller: FSM states, run modes and ALU ops.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_UP    = 3'd2,
    ST_DOWN  = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ABORT = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_BOUNCE = 2'd2
  } mode_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Raw mode 2'b11 has no run of its own and falls back to counting up.
  function automatic mode_t decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   return MODE_DOWN;
      2'b10:   return MODE_BOUNCE;
      default: return MODE_UP;
    endcase
  endfunction

endpackage

// File: rtl/counter_controller.sv
// Sequencer for the 16-bit counter datapath: up, down and bounce runs with
// pause/stop control; op/c_ld/c_clr are decoded combinationally from live status.
module counter_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned BOUNCE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  input  logic [1:0]          mode,
  input  logic [BOUNCE_W-1:0] n_bounce,
  input  logic                z,
  input  logic                m,
  output logic                op,
  output logic                c_ld,
  output logic                c_clr,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [2:0]          state_out
);

  state_t                state_q, state_d;
  state_t                ret_q, ret_d;
  mode_t                 mode_q, mode_d;
  mode_t                 start_mode;
  logic [BOUNCE_W-1:0]   rem_q, rem_d;

  assign start_mode = decode_mode(mode);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ret_q   <= ST_IDLE;
      mode_q  <= MODE_UP;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
    end
  end

  // Each active state checks stop, then pause, then status, and only then steps.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    op      = OP_ADD;
    c_ld    = 1'b0;
    c_clr   = 1'b0;
    done    = 1'b0;
    aborted = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = start_mode;
          rem_d   = (n_bounce == '0) ? BOUNCE_W'(1) : n_bounce;
          state_d = (start_mode == MODE_DOWN) ? ST_DOWN : ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (stop) begin
          state_d = ST_ABORT;
        end else if (pause) begin
          state_d = ST_PAUSE;
          ret_d   = ST_CLEAR;
        end else begin
          c_clr   = 1'b1;
          state_d = ST_UP;
        end
      end
      ST_UP: begin
        op = OP_ADD;
        if (stop) begin
          state_d = ST_ABORT;
        end else if (pause) begin
          state_d = ST_PAUSE;
          ret_d   = ST_UP;
        end else if (m) begin
          state_d = (mode_q == MODE_BOUNCE) ? ST_DOWN : ST_DONE;
        end else begin
          c_ld = 1'b1;
        end
      end
      ST_DOWN: begin
        op = OP_SUB;
        if (stop) begin
          state_d = ST_ABORT;
        end else if (pause) begin
          state_d = ST_PAUSE;
          ret_d   = ST_DOWN;
        end else if (z) begin
          if (mode_q == MODE_BOUNCE && rem_q != BOUNCE_W'(1)) begin
            rem_d   = rem_q - BOUNCE_W'(1);
            state_d = ST_UP;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          c_ld = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (stop)        state_d = ST_ABORT;
        else if (!pause) state_d = ret_q;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ABORT: begin
        aborted = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign state_out = state_q;

endmodule

// File: tb/tb_counter_controller.sv
// Bench for counter_controller paired with a behavioural 16-bit datapath; run
// timing and load counts are predicted arithmetically from the run rules.
module tb_counter_controller;

  localparam int unsigned BW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          pause = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [BW-1:0] n_bounce = '0;
  logic          z, m, op, c_ld, c_clr, busy, done, aborted;
  logic [2:0]    state_out;

  always #5 clk = ~clk;

  counter_controller #(.BOUNCE_W(BW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .n_bounce(n_bounce), .z(z), .m(m), .op(op), .c_ld(c_ld),
    .c_clr(c_clr), .busy(busy), .done(done), .aborted(aborted),
    .state_out(state_out)
  );

  // Datapath model; in fast mode the long middle of a ramp is skipped in one step.
  logic [15:0] count = '0;
  bit          fast = 1'b0;
  logic [15:0] lo_j = 16'h0010;
  logic [15:0] hi_j = 16'hFFF0;
  bit          poke_en = 1'b0;
  logic [15:0] poke_val = '0;

  function automatic logic [15:0] up1(input logic [15:0] c);
    if (fast && c == lo_j) return hi_j;
    return c + 16'd1;
  endfunction

  function automatic logic [15:0] dn1(input logic [15:0] c);
    if (fast && c == hi_j) return lo_j;
    return c - 16'd1;
  endfunction

  function automatic int dist_up(input logic [15:0] c);
    int n = 0;
    while (c != 16'hFFFF) begin c = up1(c); n++; end
    return n;
  endfunction

  function automatic int dist_down(input logic [15:0] c);
    int n = 0;
    while (c != 16'h0000) begin c = dn1(c); n++; end
    return n;
  endfunction

  always @(posedge clk) begin
    if (poke_en)    count <= poke_val;
    else if (c_clr) count <= '0;
    else if (c_ld)  count <= op ? dn1(count) : up1(count);
  end

  assign z = (count == 16'h0000);
  assign m = (count == 16'hFFFF);

  int ncmp = 0;
  int nfail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int cyc, lds, clrs, first_ld, m_rises;
  bit prev_m, ended;

  task automatic poke(input logic [15:0] v);
    @(negedge clk);
    poke_val = v;
    poke_en  = 1'b1;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic start_run(input logic [1:0] md, input logic [BW-1:0] nb);
    @(negedge clk);
    mode     = md;
    n_bounce = nb;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    mode     = 2'($urandom);
    n_bounce = BW'($urandom);
    cyc = 0; lds = 0; clrs = 0; first_ld = -1; m_rises = 0;
    prev_m = m;
  endtask

  // cyc counts cycles after the start cycle; p_*/s_at/b_at inject pause, stop, start.
  task automatic run(input int budget, input int p_at, input int p_len,
                     input int s_at, input int b_at);
    ended = 1'b0;
    while (!ended && cyc < budget) begin
      @(negedge clk);
      cyc++;
      pause = (cyc >= p_at && cyc < p_at + p_len);
      stop  = (cyc == s_at);
      start = (cyc == b_at);
      #1;
      if (c_ld) begin lds++; if (first_ld < 0) first_ld = cyc; end
      if (c_clr) clrs++;
      if (m && !prev_m) m_rises++;
      prev_m = m;
      if (done || aborted) ended = 1'b1;
    end
    pause = 1'b0;
    stop  = 1'b0;
    start = 1'b0;
    check("run_ends_in_budget", 32'(ended), 32'd1);
  endtask

  initial begin
    int L, D, Lu, Ld, R, o, k, s, n;
    logic [1:0]    md;
    logic [BW-1:0] nb;
    logic [15:0]   v, c;

    // Reset held for three cycles, with start ignored while low
    start = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_outs", 32'({op, c_ld, c_clr, busy, done, aborted}), 32'd0);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_state", 32'(state_out), 32'd0);
    check("post_rst_outs", 32'({op, c_ld, c_clr, busy, done, aborted}), 32'd0);

    // Full-length up run; a start mid-run and one in the DONE cycle are ignored
    fast = 1'b0;
    md = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
    L = dist_up(16'h0000);
    start_run(md, '0);
    run(70000, 0, 0, 0, 1000);
    check("up_cycles", 32'(cyc), 32'(L + 3));
    check("up_loads", 32'(lds), 32'(L));
    check("up_clears", 32'(clrs), 32'd1);
    check("up_first_ld", 32'(first_ld), 32'd2);
    check("up_count", 32'(count), 32'hFFFF);
    check("up_done", 32'(done), 32'd1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    #1;
    check("done_start_state", 32'(state_out), 32'd0);
    check("done_start_busy", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    @(negedge clk);
    #1;
    check("done_start_noclr", 32'({c_clr, state_out}), 32'd0);

    // Down from FFFF with a compressed ramp, then down from zero
    fast = 1'b1;
    lo_j = 16'($urandom_range(1, 40));
    hi_j = 16'hFFFF - 16'($urandom_range(1, 40));
    D = dist_down(count);
    start_run(2'b01, '0);
    run(1000, 0, 0, 0, 0);
    check("down_cycles", 32'(cyc), 32'(D + 2));
    check("down_loads", 32'(lds), 32'(D));
    check("down_first_ld", 32'(first_ld), 32'd1);
    check("down_clears", 32'(clrs), 32'd0);
    check("down_count", 32'(count), 32'd0);
    start_run(2'b01, '0);
    run(100, 0, 0, 0, 0);
    check("down0_cycles", 32'(cyc), 32'd2);
    check("down0_loads", 32'(lds), 32'd0);

    fast = 1'b0;
    repeat (3) begin
      v = 16'($urandom_range(1, 300));
      poke(v);
      start_run(2'b01, '0);
      run(1000, 0, 0, 0, 0);
      check("rdown_cycles", 32'(cyc), 32'(v) + 32'd2);
      check("rdown_loads", 32'(lds), 32'(v));
      check("rdown_count", 32'(count), 32'd0);
    end

    // Bounce runs, including n_bounce = 0 behaving as a single bounce
    fast = 1'b1;
    Lu = dist_up(16'h0000);
    Ld = dist_down(16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      nb = (i == 0) ? BW'(2) : (i == 1) ? BW'(0) : (i == 2) ? BW'(1)
                                       : BW'($urandom_range(1, 4));
      R = (nb == '0) ? 1 : int'(nb);
      start_run(2'b10, nb);
      run(5000, 0, 0, 0, 0);
      check("bounce_cycles", 32'(cyc), 32'(2 + R * (Lu + Ld + 2)));
      check("bounce_loads", 32'(lds), 32'(R * (Lu + Ld)));
      check("bounce_peaks", 32'(m_rises), 32'(R));
      check("bounce_done", 32'({done, aborted}), 32'b10);
      check("bounce_count", 32'(count), 32'd0);
    end

    // Directed pause at 100, then stop together with pause at 200
    fast = 1'b0;
    start_run(2'b00, '0);
    k = 0;
    while (count != 16'd100 && k < 300) begin @(negedge clk); k++; end
    check("reach_100", 32'(count), 32'd100);
    pause = 1'b1;
    #1;
    check("pause_blocks_ld", 32'(c_ld), 32'd0);
    repeat (4) begin
      @(negedge clk);
      #1;
      check("pause_state", 32'(state_out), 32'd4);
      check("pause_hold", 32'({c_ld, count}), 32'd100);
    end
    @(negedge clk);
    pause = 1'b0;
    #1;
    check("pause_fall_state", 32'(state_out), 32'd4);
    @(negedge clk);
    #1;
    check("resume_state", 32'(state_out), 32'd2);
    check("resume_ld", 32'({c_ld, count}), 32'h10064);
    @(negedge clk);
    #1;
    check("resume_101", 32'(count), 32'd101);
    k = 0;
    while (count != 16'd200 && k < 300) begin @(negedge clk); k++; end
    stop  = 1'b1;
    pause = 1'b1;
    #1;
    check("stop_blocks_ld", 32'(c_ld), 32'd0);
    @(negedge clk);
    stop  = 1'b0;
    pause = 1'b0;
    #1;
    check("abort_pulse", 32'({aborted, done, state_out}), 32'b10_110);
    check("abort_count", 32'(count), 32'd200);
    @(negedge clk);
    #1;
    check("abort_idle", 32'({busy, aborted, state_out}), 32'd0);
    check("abort_retain", 32'(count), 32'd200);

    // Randomized pauses (each costs its length plus one) with stray starts
    fast = 1'b1;
    L = dist_up(16'h0000);
    repeat (4) begin
      o = $urandom_range(1, L + 2);
      k = $urandom_range(1, 6);
      start_run(2'b00, '0);
      run(1000, o, k, 0, $urandom_range(2, L));
      check("rpause_cycles", 32'(cyc), 32'(L + 3 + k + 1));
      check("rpause_loads", 32'(lds), 32'(L));
      check("rpause_clears", 32'(clrs), 32'd1);
      check("rpause_done", 32'({done, aborted}), 32'b10);
    end

    // Randomized stop points, including during CLEAR and the max-hit cycle
    repeat (4) begin
      s = $urandom_range(1, L + 2);
      c = count;
      start_run(2'b00, '0);
      run(1000, 0, 0, s, 0);
      if (s >= 2) begin
        c = 16'h0000;
        n = s - 2;
        for (int j = 0; j < n; j++) c = up1(c);
      end
      check("rstop_cycles", 32'(cyc), 32'(s + 1));
      check("rstop_flags", 32'({done, aborted}), 32'b01);
      check("rstop_count", 32'(count), 32'(c));
    end

    // Reset mid-run cancels at once with no completion pulse
    fast = 1'b0;
    start_run(2'b00, '0);
    repeat (50) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_state", 32'(state_out), 32'd0);
    check("midrst_outs", 32'({op, c_ld, c_clr, busy, done, aborted}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      check("midrst_quiet", 32'({busy, done, aborted, state_out}), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
